// File: rtl/classifier_sched_if.sv
// -----------------------------------------------------------------------------
// classifier_sched_if
//   Bundles the requester handshake, the classifier-engine handshake and the
//   tagged response of the classifier scheduler.
//
//   slave  modport : scheduler side (classifier_sched)
//   master modport : surrounding logic (feature pipelines + engine)
//
//   req       requester job requests, level, held until granted
//   gnt       one-hot grant pulse
//   sel       engine input-matrix mux select
//   busy      scheduler not idle
//   eng_start engine start pulse
//   eng_done  engine done pulse
//   eng_max   engine class index, valid with eng_done
//   rsp_valid response pulse
//   rsp_id    requester owning the response
//   rsp_class class index of the response
//   rsp_err   job aborted by the watchdog
// -----------------------------------------------------------------------------
interface classifier_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    sel;
    logic               busy;
    logic               eng_start;
    logic               eng_done;
    logic [3:0]         eng_max;
    logic               rsp_valid;
    logic [ID_W-1:0]    rsp_id;
    logic [3:0]         rsp_class;
    logic               rsp_err;

    modport slave (
        input  req, eng_done, eng_max,
        output gnt, sel, busy, eng_start, rsp_valid, rsp_id, rsp_class, rsp_err
    );

    modport master (
        output req, eng_done, eng_max,
        input  gnt, sel, busy, eng_start, rsp_valid, rsp_id, rsp_class, rsp_err
    );
endinterface

// File: rtl/classifier_sched.sv
// -----------------------------------------------------------------------------
// classifier_sched
//   Shares one classifier dot-product engine between NUM_REQ feature-map
//   producers. Requests are arbitrated round-robin; the winner drives the
//   engine input mux select, the engine is started, and its class index is
//   returned tagged with the requester ID.
//
//   Ports:
//     clk   clock
//     rst   synchronous active-high reset
//     bus   classifier_sched_if.slave (req/gnt, engine handshake, response)
//
//   Build option:
//     CLS_WDOG_EN  when defined, a WAIT watchdog of TIMEOUT cycles aborts a
//                  job that the engine never finishes (rsp_err=1, class 0).
//                  When undefined, WAIT leaves only on eng_done and rsp_err
//                  is constant 0.
//
//   All outputs come straight from registers; each *_d is the value the
//   output takes in the state being entered.
// -----------------------------------------------------------------------------
module classifier_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    classifier_sched_if.slave bus
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("classifier_sched: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("classifier_sched: TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    sel_q, sel_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               eng_start_q, eng_start_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [3:0]         rsp_class_q, rsp_class_d;

`ifdef CLS_WDOG_EN
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             rsp_err_q, rsp_err_d;
`endif

    // -------------------------------------------------------------------------
    // Round-robin winner: rotate req so that bit 0 is requester ptr, take the
    // lowest set bit, then rotate the index back.
    // -------------------------------------------------------------------------
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W-1:0]      rot_idx;
    logic                 req_any;
    logic [ID_W:0]        win_sum;
    logic [ID_W-1:0]      winner;

    assign req_dbl = {bus.req, bus.req};
    assign req_rot = req_dbl[{1'b0, ptr_q} +: NUM_REQ];

    always_comb begin
        rot_idx = '0;
        req_any = 1'b0;
        // Descending scan so the lowest set bit is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = ID_W'(i);
                req_any = 1'b1;
            end
        end
    end

    assign win_sum = {1'b0, ptr_q} + {1'b0, rot_idx};
    assign winner  = (win_sum >= (ID_W+1)'(NUM_REQ))
                   ? ID_W'(win_sum - (ID_W+1)'(NUM_REQ))
                   : win_sum[ID_W-1:0];

    // The grant pulse is loaded on the IDLE->GRANT edge so it is high exactly
    // while the FSM sits in GRANT.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
        assign gnt_d[gi] = (state_q == S_IDLE) && req_any && (winner == ID_W'(gi));
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        rsp_id_d    = rsp_id_q;
        rsp_class_d = rsp_class_q;
`ifdef CLS_WDOG_EN
        timer_d     = timer_q;
        rsp_err_d   = rsp_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    state_d = S_GRANT;
                    sel_d   = winner;
                end
            end

            S_GRANT: begin
                state_d = S_START;
            end

            S_START: begin
                state_d = S_WAIT;
`ifdef CLS_WDOG_EN
                timer_d = '0;
`endif
            end

            S_WAIT: begin
                // A done arriving in the timeout cycle is honoured: it is
                // tested before the watchdog.
                if (bus.eng_done) begin
                    state_d     = S_RESP;
                    rsp_id_d    = sel_q;
                    rsp_class_d = bus.eng_max;
`ifdef CLS_WDOG_EN
                    rsp_err_d   = 1'b0;
                end else if (timer_q == TMR_LAST) begin
                    state_d     = S_RESP;
                    rsp_id_d    = sel_q;
                    rsp_class_d = 4'd0;
                    rsp_err_d   = 1'b1;
                end else if (timer_q != {TMR_W{1'b1}}) begin
                    timer_d     = timer_q + 1'b1;
`endif
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
                ptr_d   = (sel_q == ID_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        eng_start_d = (state_d == S_START);
        rsp_valid_d = (state_d == S_RESP);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_class_q <= 4'd0;
`ifdef CLS_WDOG_EN
            timer_q     <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            eng_start_q <= eng_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_class_q <= rsp_class_d;
`ifdef CLS_WDOG_EN
            timer_q     <= timer_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
    assign bus.eng_start = eng_start_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_class = rsp_class_q;
`ifdef CLS_WDOG_EN
    assign bus.rsp_err   = rsp_err_q;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_classifier_sched.sv
// -----------------------------------------------------------------------------
// tb_classifier_sched
//   Directed bench for classifier_sched with an expected-grant queue and an
//   expected-response queue filled by the stimulus process and drained by an
//   independent monitor. A small engine model answers eng_start after a
//   programmable delay. With CLS_WDOG_EN defined the DUT is built with
//   TIMEOUT=16 and the watchdog cases run; otherwise the long-stall case runs.
// -----------------------------------------------------------------------------
module tb_classifier_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
`ifdef CLS_WDOG_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1024;
`endif

    typedef struct {
        int id;
        int cls;
        int err;
    } rsp_t;

    logic clk;
    logic rst;
    int   cyc = 0;

    classifier_sched_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus_if ();

    classifier_sched #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_gnt = 0;
    int   n_rsp = 0;
    int   gnt_cyc = -1;
    int   start_cyc = -1;
    int   rsp_cyc = -1;
    logic [NUM_REQ-1:0] exp_gnt[$];
    rsp_t exp_rsp[$];

    // Engine model controls
    int         eng_delay = 8;
    logic [3:0] eng_class = 4'd3;
    bit         eng_respond = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_gnt(input int base, input int max_cyc, input string what);
        int k;
        k = 0;
        while (n_gnt == base && k < max_cyc) begin
            tick();
            k++;
        end
        if (n_gnt == base) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no gnt within %0d cycles, required one", what, max_cyc);
        end
    endtask

    task automatic wait_rsp(input int base, input int max_cyc, input string what);
        int k;
        k = 0;
        while (n_rsp == base && k < max_cyc) begin
            tick();
            k++;
        end
        if (n_rsp == base) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no rsp_valid within %0d cycles, required one", what, max_cyc);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_gnt"},       32'(bus_if.gnt),       32'd0);
        check({tag, "_sel"},       32'(bus_if.sel),       32'd0);
        check({tag, "_busy"},      32'(bus_if.busy),      32'd0);
        check({tag, "_eng_start"}, 32'(bus_if.eng_start), 32'd0);
        check({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
        check({tag, "_rsp_id"},    32'(bus_if.rsp_id),    32'd0);
        check({tag, "_rsp_class"}, 32'(bus_if.rsp_class), 32'd0);
        check({tag, "_rsp_err"},   32'(bus_if.rsp_err),   32'd0);
    endtask

    task automatic expect_job(input logic [NUM_REQ-1:0] g, input int id, input int cls, input int err);
        rsp_t e;
        e.id  = id;
        e.cls = cls;
        e.err = err;
        exp_gnt.push_back(g);
        exp_rsp.push_back(e);
    endtask

    // Engine model: answers a start after eng_delay cycles; eng_max carries
    // a distractor value whenever done is low.
    initial begin : engine
        int         dly;
        logic [3:0] cls;
        bus_if.eng_done = 1'b0;
        bus_if.eng_max  = 4'hE;
        forever begin
            @(negedge clk);
            if (bus_if.eng_start === 1'b1 && eng_respond) begin
                dly = eng_delay;
                cls = eng_class;
                repeat (dly) @(negedge clk);
                bus_if.eng_done = 1'b1;
                bus_if.eng_max  = cls;
                @(negedge clk);
                bus_if.eng_done = 1'b0;
                bus_if.eng_max  = ~cls;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a grant or response.
    initial begin : monitor
        rsp_t             e;
        logic [NUM_REQ-1:0] g;
        forever begin
            @(negedge clk);
            if (bus_if.eng_start === 1'b1) start_cyc = cyc;
            if (bus_if.gnt !== '0) begin
                gnt_cyc = cyc;
                $display("gnt: cycle %0d gnt=%b sel=%0d", cyc, bus_if.gnt, bus_if.sel);
                if (exp_gnt.size() == 0) begin
                    check("gnt_unexpected", 32'(bus_if.gnt), 32'd0);
                end else begin
                    g = exp_gnt.pop_front();
                    check("gnt_onehot", 32'(bus_if.gnt), 32'(g));
                end
                n_gnt++;
            end
            if (bus_if.rsp_valid === 1'b1) begin
                rsp_cyc = cyc;
                $display("rsp: cycle %0d id=%0d class=%0d err=%0d",
                         cyc, bus_if.rsp_id, bus_if.rsp_class, bus_if.rsp_err);
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 32'(bus_if.rsp_valid), 32'd0);
                end else begin
                    e = exp_rsp.pop_front();
                    check("rsp_id",    32'(bus_if.rsp_id),    32'(e.id));
                    check("rsp_class", 32'(bus_if.rsp_class), 32'(e.cls));
                    check("rsp_err",   32'(bus_if.rsp_err),   32'(e.err));
                end
                n_rsp++;
            end
        end
    end

    // Stimulus
    initial begin : stim
        int c0;
        int g0;
        int r0;
        rst        = 1'b1;
        bus_if.req = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_idle("reset");

        // Single job: requester 1, class 3 eight cycles after start
        eng_delay = 8;
        eng_class = 4'd3;
        expect_job(4'b0010, 1, 3, 0);
        c0 = cyc; g0 = n_gnt; r0 = n_rsp;
        bus_if.req = 4'b0010;
        wait_gnt(g0, 10, "job1_gnt");
        bus_if.req = '0;
        check("job1_gnt_cycle", 32'(gnt_cyc), 32'(c0 + 1));
        check("job1_sel", 32'(bus_if.sel), 32'd1);
        tick();
        check("job1_start_cycle", 32'(start_cyc), 32'(c0 + 2));
        check("job1_busy", 32'(bus_if.busy), 32'd1);
        wait_rsp(r0, 40, "job1_rsp");
        check("job1_rsp_cycle", 32'(rsp_cyc), 32'(c0 + 11));
        tick();
        tick();
        check("job1_valid_drop", 32'(bus_if.rsp_valid), 32'd0);
        check("job1_class_hold", 32'(bus_if.rsp_class), 32'd3);
        check("job1_idle_busy", 32'(bus_if.busy), 32'd0);

        // Round-robin restart: ptr is 2, so 0011 wraps to requester 0
        eng_delay = 2;
        eng_class = 4'd10;
        expect_job(4'b0001, 0, 10, 0);
        g0 = n_gnt; r0 = n_rsp;
        bus_if.req = 4'b0011;
        wait_gnt(g0, 10, "restart_gnt");
        bus_if.req = '0;
        wait_rsp(r0, 40, "restart_rsp");

        // Reset, then all four requesting: order 0,1,2,3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_job(4'b0001, 0, 7, 0);
        expect_job(4'b0010, 1, 9, 0);
        expect_job(4'b0100, 2, 15, 0);
        expect_job(4'b1000, 3, 0, 0);
        bus_if.req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin eng_delay = 1; eng_class = 4'd7;  end
                1: begin eng_delay = 3; eng_class = 4'd9;  end
                2: begin eng_delay = 2; eng_class = 4'd15; end
                default: begin eng_delay = 5; eng_class = 4'd0; end
            endcase
            g0 = n_gnt; r0 = n_rsp;
            wait_gnt(g0, 20, "rr_gnt");
            bus_if.req[k] = 1'b0;
            wait_rsp(r0, 40, "rr_rsp");
        end

        // Job for requester 2 leaves ptr at 3 and class 6 in rsp_class
        eng_delay = 4;
        eng_class = 4'd6;
        expect_job(4'b0100, 2, 6, 0);
        g0 = n_gnt; r0 = n_rsp;
        bus_if.req = 4'b0100;
        wait_gnt(g0, 10, "pre_rst_gnt");
        bus_if.req = '0;
        wait_rsp(r0, 40, "pre_rst_rsp");

        // Job for requester 3 is reset while in WAIT; engine answers later,
        // when the scheduler is idle, and must be ignored.
        eng_delay = 20;
        eng_class = 4'd9;
        exp_gnt.push_back(4'b1000);
        g0 = n_gnt;
        bus_if.req = 4'b1000;
        wait_gnt(g0, 10, "midrst_gnt");
        bus_if.req = '0;
        repeat (4) tick();
        check("midrst_busy_before", 32'(bus_if.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("midrst");
        r0 = n_rsp;
        repeat (25) tick();
        check("spurious_done_no_rsp", 32'(n_rsp), 32'(r0));
        check("spurious_done_busy", 32'(bus_if.busy), 32'd0);

        // ptr back to 0 after reset: 1111 grants requester 0, not 3
        eng_delay = 3;
        eng_class = 4'd12;
        expect_job(4'b0001, 0, 12, 0);
        g0 = n_gnt; r0 = n_rsp;
        bus_if.req = 4'b1111;
        wait_gnt(g0, 10, "post_rst_gnt");
        bus_if.req = '0;
        wait_rsp(r0, 40, "post_rst_rsp");
        tick();

`ifdef CLS_WDOG_EN
        // Engine never answers: abort 16 cycles after entering WAIT
        eng_respond = 1'b0;
        expect_job(4'b0010, 1, 0, 1);
        c0 = cyc; g0 = n_gnt; r0 = n_rsp;
        bus_if.req = 4'b0010;
        wait_gnt(g0, 10, "wdog_gnt");
        bus_if.req = '0;
        wait_rsp(r0, 60, "wdog_rsp");
        check("wdog_rsp_cycle", 32'(rsp_cyc), 32'(c0 + 19));
        tick();

        // Done in the timeout cycle wins
        eng_respond = 1'b1;
        eng_delay   = 16;
        eng_class   = 4'd11;
        expect_job(4'b0100, 2, 11, 0);
        c0 = cyc; g0 = n_gnt; r0 = n_rsp;
        bus_if.req = 4'b0100;
        wait_gnt(g0, 10, "tie_gnt");
        bus_if.req = '0;
        wait_rsp(r0, 60, "tie_rsp");
        check("tie_rsp_cycle", 32'(rsp_cyc), 32'(c0 + 19));
        tick();
`else
        // Long engine stall: no timeout, single response with class 5
        eng_delay = 5000;
        eng_class = 4'd5;
        expect_job(4'b0010, 1, 5, 0);
        c0 = cyc; g0 = n_gnt; r0 = n_rsp;
        bus_if.req = 4'b0010;
        wait_gnt(g0, 10, "stall_gnt");
        bus_if.req = '0;
        wait_rsp(r0, 6000, "stall_rsp");
        check("stall_rsp_cycle", 32'(rsp_cyc), 32'(c0 + 5003));
        repeat (5) tick();
        check("stall_single_rsp", 32'(n_rsp), 32'(r0 + 1));
`endif

        check("left_exp_gnt", 32'(exp_gnt.size()), 32'd0);
        check("left_exp_rsp", 32'(exp_rsp.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/classifier_sched.md
# classifier_sched

Scheduler sharing the single 16x6 classifier dot-product engine between `NUM_REQ` feature-map producers. It arbitrates requests round-robin and drives the engine's input-matrix mux select. It pulses the engine start, waits for the engine's done pulse, then returns the class index, tagged with the requester ID. It sits between the per-channel feature pipelines and the classifier engine in the top level.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `ID_W`, `$clog2(NUM_REQ)`, requester ID width
- `TIMEOUT`, 1024, maximum WAIT cycles before a job is aborted (watchdog builds only)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `req`  in  NUM_REQ  per-requester job request; level, held until granted
- `gnt`  out  NUM_REQ  one-hot grant, 1-cycle pulse
- `sel`  out  ID_W  engine input mux select; valid from GRANT through RESP
- `busy`  out  1  high in every state except IDLE
- `eng_start`  out  1  engine start, 1-cycle pulse
- `eng_done`  in  1  engine done, 1-cycle pulse
- `eng_max`  in  4  engine class index; valid when `eng_done`=1
- `rsp_valid`  out  1  response pulse, 1 cycle
- `rsp_id`  out  ID_W  requester that owns the response
- `rsp_class`  out  4  class index
- `rsp_err`  out  1  job aborted by the watchdog

## Operation
States:
- IDLE
  - `|req` -> GRANT.
  - Winner: first set bit of `req` searching upward from `ptr`, wrapping.
  - Winner is registered into `sel`.
- GRANT
  - `gnt[sel]`=1 for this cycle -> START.
- START
  - `eng_start`=1 for this cycle.
  - WAIT timer cleared -> WAIT.
- WAIT
  - `eng_done`: `rsp_class` <= `eng_max`, `rsp_err` <= 0 -> RESP.
  - Otherwise timer++.
  - Timer == TIMEOUT-1 without `eng_done`: `rsp_class` <= 0, `rsp_err` <= 1 -> RESP.
- RESP
  - `rsp_valid`=1, `rsp_id`=`sel`.
  - `ptr` <= (`sel`+1) mod NUM_REQ -> IDLE.

Rules:
- `ptr` resets to 0. It advances only in RESP.
- A request dropped before grant is simply not chosen. Requests arriving during a job wait; there is no queueing beyond `req`.
- `eng_done` outside WAIT is ignored.
- `eng_done` in the timeout cycle: done wins and `rsp_err`=0.
- Timer width is `$clog2(TIMEOUT)`; it saturates and never wraps.
- `rsp_class` and `rsp_err` hold their last values outside RESP; `rsp_valid` qualifies them.

## Timing
- Reset values: state IDLE; `gnt`=0, `sel`=0, `busy`=0, `eng_start`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_class`=0, `rsp_err`=0; `ptr`=0; timer 0.
- Reset mid-job returns to IDLE next edge with all outputs at reset values. The engine shares `rst`, so no abort handshake exists.
- Latency:
  - `req` sampled in IDLE at cycle 0 -> `gnt` cycle 1 -> `eng_start` cycle 2.
  - `eng_done` at cycle N -> `rsp_valid` at cycle N+1.
- Back-to-back: RESP -> IDLE -> GRANT. Minimum 2 cycles between `rsp_valid` and the next `gnt`.
- All outputs are registered.

## Configuration
- `CLS_WDOG_EN` defined: watchdog timer and abort path are compiled in, as described above.
- `CLS_WDOG_EN` undefined:
  - WAIT leaves only on `eng_done`.
  - Timer logic is removed and `rsp_err` is tied to 0.
  - `TIMEOUT` is unused.

## Test plan
- Single job: `req`=4'b0010 at cycle 0, engine model returns `eng_max`=3 eight cycles after start -> `gnt`=4'b0010 at cycle 1, `eng_start` at cycle 2, `rsp_valid` with `rsp_id`=1, `rsp_class`=3, `rsp_err`=0 one cycle after `eng_done`.
- Round-robin: `req`=4'b1111 held, one request dropped after each grant -> grant order 0,1,2,3.
- Round-robin restart: after job 1 completes, `req`=4'b0011 -> requester 0 wins.
- Watchdog (`CLS_WDOG_EN`, TIMEOUT=16): engine never answers -> `rsp_valid` with `rsp_err`=1, `rsp_class`=0 exactly 16 cycles after entering WAIT.
- Watchdog tie: `eng_done` lands in the timeout cycle -> `rsp_err`=0, class taken from `eng_max`.
- Reset and spurious done: `rst` pulsed in WAIT -> all outputs 0 and `ptr`=0 next cycle. An `eng_done` pulse while IDLE -> no `rsp_valid`.
- No-watchdog build: engine stalls 5000 cycles then `eng_done` with `eng_max`=5 -> single response, class 5, `rsp_err`=0.
